fifo_sync_return_pkt: RTL and testbench
=======================================

FIFO_SYNC_RETURN_PKT -- requirements
Module: fifo_sync_return_pkt

Interface
REQ-001 The block SHALL have these parameters:
- C_WIDTH, default 32: data width in bits.
- C_DEPTH, default 64: word capacity; a power of 2 and at least 4.
- C_RD_RETURN_EN, default 0: 1 enables read-side commit/rollback.
- C_WR_PROG_FULL_THRESH, default C_DEPTH-8: prog-full level in words.
- C_COUNT_WIDTH, default 16: width of the data-count outputs.
- C_DBG_COUNT_WIDTH, default 16: width of the debug counters.

REQ-002 The block SHALL have these ports:
- CLK_I  in  1  single clock; all logic on its rising edge.
- RST_I  in  1  synchronous, active-high reset.
- WR_EN_I  in  1  write request.
- WR_DATA_I  in  C_WIDTH  write data.
- WR_SUCC_I  in  1  commit all pending writes.
- WR_FAIL_I  in  1  discard all pending writes.
- WR_EN_VALID_O  out  1  write accepted this cycle.
- WR_FULL_O  out  1  no free word.
- WR_PROG_FULL_O  out  1  WR_DATA_COUNT_O >= C_WR_PROG_FULL_THRESH.
- WR_DATA_COUNT_O  out  C_COUNT_WIDTH  occupied words, including pending words.
- WR_PEND_COUNT_O  out  C_COUNT_WIDTH  uncommitted write words.
- WR_TXN_OPEN_O  out  1  write transaction open.
- WR_DEADLOCK_O  out  1  FIFO is full of pending data only.
- RD_EN_I  in  1  read request.
- RD_SUCC_I  in  1  commit reads (used only when C_RD_RETURN_EN=1).
- RD_FAIL_I  in  1  rewind reads (used only when C_RD_RETURN_EN=1).
- RD_DATA_O  out  C_WIDTH  FWFT data.
- RD_DATA_VALID_O  out  1  read accepted this cycle.
- RD_EMPTY_O  out  1  no committed unread word.
- RD_DATA_COUNT_O  out  C_COUNT_WIDTH  committed unread words.
- WR_EN_NAMES_O, WR_EN_ACCUS_O, RD_EN_NAMES_O, RD_EN_ACCUS_O  out  C_DBG_COUNT_WIDTH each  debug counters.

Function
REQ-003 The block SHALL keep four pointers of log2(C_DEPTH)+1 bits that wrap modulo 2*C_DEPTH: wr_spec, wr_cmt, rd_spec and rd_cmt.
REQ-004 The block SHALL assert WR_FULL_O combinationally when (wr_spec - rd_cmt) == C_DEPTH.
REQ-005 The block SHALL assert RD_EMPTY_O combinationally when rd_spec == wr_cmt.
REQ-006 The block SHALL drive WR_EN_VALID_O = WR_EN_I & ~WR_FULL_O; an accepted write stores WR_DATA_I at wr_spec and increments wr_spec at the next edge.
REQ-007 The block SHALL drive RD_DATA_O combinationally from mem[rd_spec] (FWFT), with don't-care content while RD_EMPTY_O=1.
REQ-008 The block SHALL drive RD_DATA_VALID_O = RD_EN_I & ~RD_EMPTY_O; an accepted read increments rd_spec.
REQ-009 On WR_SUCC_I, wr_cmt SHALL load the post-edge wr_spec, so a write accepted in the same cycle is included; reader visibility begins the cycle after.
REQ-010 On WR_FAIL_I, wr_spec SHALL load wr_cmt and the block SHALL discard any write accepted in the same cycle.
REQ-011 When WR_SUCC_I and WR_FAIL_I are both high, WR_FAIL_I SHALL win.
REQ-012 When C_RD_RETURN_EN=0, rd_cmt SHALL equal rd_spec at every edge, so read space frees one cycle after each read.
REQ-013 When C_RD_RETURN_EN=1, RD_SUCC_I SHALL make rd_cmt load the post-edge rd_spec, RD_FAIL_I SHALL make rd_spec load rd_cmt (a read in the same cycle is cancelled), and FAIL SHALL win over SUCC.
REQ-014 The write-side FSM SHALL have two states:
- IDLE: go to OPEN on an accepted write without WR_SUCC_I/WR_FAIL_I in that cycle.
- OPEN: go to IDLE on WR_SUCC_I or WR_FAIL_I.
- WR_TXN_OPEN_O = (state == OPEN).
REQ-015 The block SHALL output WR_PEND_COUNT_O = wr_spec - wr_cmt, WR_DATA_COUNT_O = wr_spec - rd_cmt and RD_DATA_COUNT_O = wr_cmt - rd_spec, each zero-extended to C_COUNT_WIDTH.
REQ-016 The block SHALL set WR_DEADLOCK_O (registered) when WR_FULL_O=1 and wr_cmt == rd_cmt; it SHALL remain set until WR_SUCC_I, WR_FAIL_I or RST_I.
REQ-017 Simultaneous read and write at the full or empty boundary SHALL evaluate against pre-edge flags only, with no write-to-read bypass.

Reset
REQ-018 While RST_I is high at an edge, the block SHALL clear all pointers and the debug counters, set the FSM to IDLE and clear WR_DEADLOCK_O.
REQ-019 After reset, the block SHALL present RD_EMPTY_O=1, WR_FULL_O=0, WR_PROG_FULL_O=0 (C_WR_PROG_FULL_THRESH>0), all counts 0, and WR_EN_VALID_O=RD_DATA_VALID_O=0 while RST_I is high.
REQ-020 Reset in mid-transaction SHALL discard all pending and committed data; RAM contents are not cleared.

Configuration
REQ-021 When macro FIFO_RETURN_DBG_CNT_EN is defined, the block SHALL count as follows, each counter wrapping modulo 2^C_DBG_COUNT_WIDTH:
- WR_EN_NAMES_O: cycles with WR_EN_I=1.
- WR_EN_ACCUS_O: cycles with WR_EN_VALID_O=1.
- RD_EN_NAMES_O: cycles with RD_EN_I=1.
- RD_EN_ACCUS_O: cycles with RD_DATA_VALID_O=1.
REQ-022 When FIFO_RETURN_DBG_CNT_EN is undefined, the block SHALL tie the four debug outputs to 0 and synthesise no counter registers.

Verification
REQ-023 The bench SHALL cover these scenarios:
- Write 5 words, then WR_SUCC_I: RD_EMPTY_O falls the cycle after SUCC and RD_DATA_COUNT_O=5; WR_PEND_COUNT_O counts 1..5 and then 0.
- Write 3 words, then WR_FAIL_I together with a 4th write: WR_DATA_COUNT_O returns to 0, RD_EMPTY_O stays 1 and FSM returns to IDLE.
- C_DEPTH=8, write 8 words uncommitted: WR_FULL_O=1, WR_DEADLOCK_O=1 next cycle and a 9th write gives WR_EN_VALID_O=0; WR_FAIL_I clears both flags.
- C_RD_RETURN_EN=1, commit 4 words, read 2, then RD_FAIL_I: RD_DATA_O again shows word 0 and RD_DATA_COUNT_O=4; read 4 then RD_SUCC_I gives WR_DATA_COUNT_O=0.
- Full FIFO with simultaneous read and write: the write is rejected, the read is accepted, and the write succeeds the next cycle; pointers wrap across 3*C_DEPTH words with data order intact.
- Define the macro and drive 10 WR_EN_I cycles while full for 4 of them: NAMES=10, ACCUS=6; with the macro undefined all four counters read 0.

Source files
------------

// File: rtl/fifo_sync_return_pkt.sv
// fifo_sync_return_pkt: single-clock FWFT FIFO with write commit/discard, optional read commit/rewind; debug counters when FIFO_RETURN_DBG_CNT_EN is defined
module fifo_sync_return_pkt #(
   parameter int C_WIDTH               = 32,
   parameter int C_DEPTH               = 64,
   parameter int C_RD_RETURN_EN        = 0,
   parameter int C_WR_PROG_FULL_THRESH = C_DEPTH - 8,
   parameter int C_COUNT_WIDTH         = 16,
   parameter int C_DBG_COUNT_WIDTH     = 16
) (
   input  logic                         CLK_I,
   input  logic                         RST_I,
   input  logic                         WR_EN_I,
   input  logic [C_WIDTH-1:0]           WR_DATA_I,
   input  logic                         WR_SUCC_I,
   input  logic                         WR_FAIL_I,
   output logic                         WR_EN_VALID_O,
   output logic                         WR_FULL_O,
   output logic                         WR_PROG_FULL_O,
   output logic [C_COUNT_WIDTH-1:0]     WR_DATA_COUNT_O,
   output logic [C_COUNT_WIDTH-1:0]     WR_PEND_COUNT_O,
   output logic                         WR_TXN_OPEN_O,
   output logic                         WR_DEADLOCK_O,
   input  logic                         RD_EN_I,
   input  logic                         RD_SUCC_I,
   input  logic                         RD_FAIL_I,
   output logic [C_WIDTH-1:0]           RD_DATA_O,
   output logic                         RD_DATA_VALID_O,
   output logic                         RD_EMPTY_O,
   output logic [C_COUNT_WIDTH-1:0]     RD_DATA_COUNT_O,
   output logic [C_DBG_COUNT_WIDTH-1:0] WR_EN_NAMES_O,
   output logic [C_DBG_COUNT_WIDTH-1:0] WR_EN_ACCUS_O,
   output logic [C_DBG_COUNT_WIDTH-1:0] RD_EN_NAMES_O,
   output logic [C_DBG_COUNT_WIDTH-1:0] RD_EN_ACCUS_O
);
   localparam int AW = $clog2(C_DEPTH);
   localparam logic [AW:0] L_DEPTH = (AW+1)'(C_DEPTH);
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_OPEN = 1'b1;
   logic [C_WIDTH-1:0] mem_q [C_DEPTH];
   logic [AW:0] wr_spec_q, wr_spec_d, wr_cmt_q, wr_cmt_d;
   logic [AW:0] rd_spec_q, rd_spec_d, rd_cmt_q, rd_cmt_d;
   logic [AW:0] wr_spec_inc, rd_spec_inc, occ, pend, avail;
   logic [0:0] state_q, state_d;
   logic deadlock_q, deadlock_d, full, empty, wr_ok, rd_ok;
   assign occ   = wr_spec_q - rd_cmt_q;
   assign pend  = wr_spec_q - wr_cmt_q;
   assign avail = wr_cmt_q - rd_spec_q;
   assign full  = occ == L_DEPTH;
   assign empty = rd_spec_q == wr_cmt_q;
   assign wr_ok = WR_EN_I & ~full & ~RST_I;
   assign rd_ok = RD_EN_I & ~empty & ~RST_I;
   assign wr_spec_inc = wr_spec_q + {{AW{1'b0}}, wr_ok};
   assign rd_spec_inc = rd_spec_q + {{AW{1'b0}}, rd_ok};
   assign WR_EN_VALID_O   = wr_ok;
   assign RD_DATA_VALID_O = rd_ok;
   assign WR_FULL_O       = full;
   assign RD_EMPTY_O      = empty;
   assign WR_DATA_COUNT_O = C_COUNT_WIDTH'(occ);
   assign WR_PEND_COUNT_O = C_COUNT_WIDTH'(pend);
   assign RD_DATA_COUNT_O = C_COUNT_WIDTH'(avail);
   assign WR_PROG_FULL_O  = 32'(occ) >= 32'(C_WR_PROG_FULL_THRESH);
   assign WR_TXN_OPEN_O   = state_q == S_OPEN;
   assign WR_DEADLOCK_O   = deadlock_q;
   assign RD_DATA_O       = mem_q[rd_spec_q[AW-1:0]];
   // next-state: fail beats succ on both sides; without read return the read commit tracks every read
   always_comb begin
      wr_spec_d  = WR_FAIL_I ? wr_cmt_q : wr_spec_inc;
      wr_cmt_d   = WR_FAIL_I ? wr_cmt_q : WR_SUCC_I ? wr_spec_inc : wr_cmt_q;
      rd_spec_d  = (C_RD_RETURN_EN != 0 && RD_FAIL_I) ? rd_cmt_q : rd_spec_inc;
      rd_cmt_d   = (C_RD_RETURN_EN == 0) ? rd_spec_inc :
                   RD_FAIL_I ? rd_cmt_q : RD_SUCC_I ? rd_spec_inc : rd_cmt_q;
      state_d    = (state_q == S_OPEN) ? ((WR_SUCC_I | WR_FAIL_I) ? S_IDLE : S_OPEN) :
                   ((wr_ok & ~WR_SUCC_I & ~WR_FAIL_I) ? S_OPEN : S_IDLE);
      deadlock_d = (WR_SUCC_I | WR_FAIL_I) ? 1'b0 :
                   (full & (wr_cmt_q == rd_cmt_q)) ? 1'b1 : deadlock_q;
   end
   // pointer, transaction state and deadlock registers
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         wr_spec_q  <= '0;
         wr_cmt_q   <= '0;
         rd_spec_q  <= '0;
         rd_cmt_q   <= '0;
         state_q    <= S_IDLE;
         deadlock_q <= 1'b0;
      end else begin
         wr_spec_q  <= wr_spec_d;
         wr_cmt_q   <= wr_cmt_d;
         rd_spec_q  <= rd_spec_d;
         rd_cmt_q   <= rd_cmt_d;
         state_q    <= state_d;
         deadlock_q <= deadlock_d;
      end
   end
   // storage array, written at the speculative write pointer and never reset
   always_ff @(posedge CLK_I) begin
      if (wr_ok) mem_q[wr_spec_q[AW-1:0]] <= WR_DATA_I;
   end
`ifdef FIFO_RETURN_DBG_CNT_EN
   logic [C_DBG_COUNT_WIDTH-1:0] wr_names_q, wr_accus_q, rd_names_q, rd_accus_q;
   // request and acceptance counters, free-running with wrap
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         wr_names_q <= '0;
         wr_accus_q <= '0;
         rd_names_q <= '0;
         rd_accus_q <= '0;
      end else begin
         wr_names_q <= wr_names_q + C_DBG_COUNT_WIDTH'(WR_EN_I);
         wr_accus_q <= wr_accus_q + C_DBG_COUNT_WIDTH'(wr_ok);
         rd_names_q <= rd_names_q + C_DBG_COUNT_WIDTH'(RD_EN_I);
         rd_accus_q <= rd_accus_q + C_DBG_COUNT_WIDTH'(rd_ok);
      end
   end
   assign WR_EN_NAMES_O = wr_names_q;
   assign WR_EN_ACCUS_O = wr_accus_q;
   assign RD_EN_NAMES_O = rd_names_q;
   assign RD_EN_ACCUS_O = rd_accus_q;
`else
   assign WR_EN_NAMES_O = '0;
   assign WR_EN_ACCUS_O = '0;
   assign RD_EN_NAMES_O = '0;
   assign RD_EN_ACCUS_O = '0;
`endif
endmodule

// File: tb/tb_fifo_sync_return_pkt.sv
// tb_fifo_sync_return_pkt: randomized and directed checks of two depth-8 instances (read return off/on) against a queue model
module tb_fifo_sync_return_pkt;
`ifdef FIFO_RETURN_DBG_CNT_EN
   localparam bit DBG = 1'b1;
`else
   localparam bit DBG = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst, we, ws, wf, re, rs, rf;
   logic [31:0] wd;
   logic [31:0] rdat [2];
   logic wvld [2], full [2], pfull [2], topen [2], dlk [2], rvld [2], empt [2];
   logic [15:0] wcnt [2], pcnt [2], rcnt [2], wnm [2], wac [2], rnm [2], rac [2];
   always #5 clk = ~clk;
   for (genvar i = 0; i < 2; i++) begin : g_dut
      fifo_sync_return_pkt #(.C_DEPTH(8), .C_RD_RETURN_EN(i), .C_WR_PROG_FULL_THRESH(6)) u_dut (
         .CLK_I(clk), .RST_I(rst), .WR_EN_I(we), .WR_DATA_I(wd), .WR_SUCC_I(ws), .WR_FAIL_I(wf),
         .WR_EN_VALID_O(wvld[i]), .WR_FULL_O(full[i]), .WR_PROG_FULL_O(pfull[i]),
         .WR_DATA_COUNT_O(wcnt[i]), .WR_PEND_COUNT_O(pcnt[i]), .WR_TXN_OPEN_O(topen[i]),
         .WR_DEADLOCK_O(dlk[i]), .RD_EN_I(re), .RD_SUCC_I(rs), .RD_FAIL_I(rf),
         .RD_DATA_O(rdat[i]), .RD_DATA_VALID_O(rvld[i]), .RD_EMPTY_O(empt[i]),
         .RD_DATA_COUNT_O(rcnt[i]), .WR_EN_NAMES_O(wnm[i]), .WR_EN_ACCUS_O(wac[i]),
         .RD_EN_NAMES_O(rnm[i]), .RD_EN_ACCUS_O(rac[i]));
   end
   int total = 0, bad = 0, sel = 0;
   // model: cq = committed unread, rq = read but not yet committed, pq = written but not committed
   logic [31:0] cq [$], rq [$], pq [$];
   bit m_open, m_dl, exp_wv, exp_rv, obs_wv, obs_rv;
   int m_wn, m_wa, m_rn, m_ra;
   logic [31:0] obs_rd, exp_rd;
   function automatic int occ();
      return cq.size() + rq.size() + pq.size();
   endfunction
   task automatic m_clear();
      cq.delete(); rq.delete(); pq.delete();
      m_open = 0; m_dl = 0; m_wn = 0; m_wa = 0; m_rn = 0; m_ra = 0;
   endtask
   task automatic do_reset();
      @(negedge clk);
      rst = 1; we = 0; wd = 0; ws = 0; wf = 0; re = 0; rs = 0; rf = 0;
      @(posedge clk);
      #1 rst = 0;
      m_clear();
   endtask
   task automatic step(input bit w, input logic [31:0] d, input bit s, input bit f, input bit r,
                       input bit rsu = 0, input bit rfa = 0);
      bit pre_full, pre_nocmt;
      @(negedge clk);
      we = w; wd = d; ws = s; wf = f; re = r; rs = rsu; rf = rfa;
      #1;
      obs_wv = wvld[sel]; obs_rv = rvld[sel]; obs_rd = rdat[sel];
      pre_full = occ() == 8;
      pre_nocmt = (cq.size() + rq.size()) == 0;
      exp_wv = w && !pre_full;
      exp_rv = r && cq.size() > 0;
      exp_rd = (cq.size() > 0) ? cq[0] : 32'hx;
      @(posedge clk);
      m_wn += int'(w); m_wa += int'(exp_wv); m_rn += int'(r); m_ra += int'(exp_rv);
      if (exp_rv) rq.push_back(cq.pop_front());
      if (exp_wv) pq.push_back(d);
      if (f) pq.delete();
      else if (s) while (pq.size() > 0) cq.push_back(pq.pop_front());
      if (sel == 0 || (rsu && !rfa)) rq.delete();
      else if (rfa) while (rq.size() > 0) cq.push_front(rq.pop_back());
      m_dl = (s || f) ? 1'b0 : (pre_full && pre_nocmt) ? 1'b1 : m_dl;
      m_open = (s || f) ? 1'b0 : exp_wv ? 1'b1 : m_open;
      #1;
   endtask
   task automatic test_reset();
      sel = 0;
      do_reset();
      step(1, 1, 1, 0, 0);
      step(1, 2, 0, 0, 0);
      @(negedge clk);
      rst = 1; we = 1; re = 1; ws = 0; wf = 0;
      #1;
      total++;
      if ({wvld[0], rvld[0], wvld[1], rvld[1]} !== 4'b0) begin
         bad++; $display("FAIL reset_valids: got %b want 0000", {wvld[0], rvld[0], wvld[1], rvld[1]});
      end
      @(posedge clk);
      #1 rst = 0; we = 0; re = 0;
      m_clear();
      for (int k = 0; k < 2; k++) begin
         total++;
         if ({empt[k], full[k], pfull[k], topen[k], dlk[k]} !== 5'b10000) begin
            bad++; $display("FAIL reset_flags[%0d]: got %b want 10000", k, {empt[k], full[k], pfull[k], topen[k], dlk[k]});
         end
         total++;
         if ({wcnt[k], pcnt[k], rcnt[k]} !== 48'h0) begin
            bad++; $display("FAIL reset_counts[%0d]: got %0h want 0", k, {wcnt[k], pcnt[k], rcnt[k]});
         end
      end
   endtask
   task automatic test_commit();
      sel = 0;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         step(1, 100 + i, 0, 0, 0);
         total++;
         if (pcnt[0] !== 16'(i + 1) || empt[0] !== 1'b1) begin
            bad++; $display("FAIL commit_pend: got pend=%0d empty=%b want pend=%0d empty=1", pcnt[0], empt[0], i + 1);
         end
      end
      step(0, 0, 1, 0, 0);
      total++;
      if ({pcnt[0], rcnt[0], empt[0], topen[0]} !== {16'd0, 16'd5, 1'b0, 1'b0} || rdat[0] !== 32'd100) begin
         bad++; $display("FAIL commit_done: got pend=%0d rcnt=%0d empty=%b open=%b data=%0d want 0 5 0 0 100",
                         pcnt[0], rcnt[0], empt[0], topen[0], rdat[0]);
      end
   endtask
   task automatic test_fail();
      sel = 0;
      do_reset();
      for (int i = 0; i < 3; i++) step(1, 40 + i, 0, 0, 0);
      total++;
      if (topen[0] !== 1'b1) begin
         bad++; $display("FAIL fail_open: got %b want 1", topen[0]);
      end
      step(1, 43, 0, 1, 0);
      total++;
      if (obs_wv !== 1'b1 || wcnt[0] !== 16'd0 || empt[0] !== 1'b1 || topen[0] !== 1'b0) begin
         bad++; $display("FAIL fail_discard: got valid=%b wcnt=%0d empty=%b open=%b want 1 0 1 0",
                         obs_wv, wcnt[0], empt[0], topen[0]);
      end
   endtask
   task automatic test_deadlock();
      sel = 0;
      do_reset();
      for (int i = 0; i < 8; i++) step(1, i, 0, 0, 0);
      total++;
      if (full[0] !== 1'b1 || dlk[0] !== 1'b0) begin
         bad++; $display("FAIL dl_full: got full=%b dl=%b want 1 0", full[0], dlk[0]);
      end
      step(1, 99, 0, 0, 0);
      total++;
      if (obs_wv !== 1'b0 || dlk[0] !== 1'b1) begin
         bad++; $display("FAIL dl_set: got valid=%b dl=%b want 0 1", obs_wv, dlk[0]);
      end
      step(0, 0, 0, 1, 0);
      total++;
      if (full[0] !== 1'b0 || dlk[0] !== 1'b0 || wcnt[0] !== 16'd0) begin
         bad++; $display("FAIL dl_clear: got full=%b dl=%b wcnt=%0d want 0 0 0", full[0], dlk[0], wcnt[0]);
      end
   endtask
   task automatic test_rd_return();
      sel = 1;
      do_reset();
      for (int i = 0; i < 4; i++) step(1, 200 + i, i == 3, 0, 0);
      for (int i = 0; i < 2; i++) begin
         step(0, 0, 0, 0, 1);
         total++;
         if (obs_rv !== 1'b1 || obs_rd !== 32'(200 + i)) begin
            bad++; $display("FAIL ret_read: got valid=%b data=%0d want 1 %0d", obs_rv, obs_rd, 200 + i);
         end
      end
      step(0, 0, 0, 0, 0, 0, 1);
      total++;
      if (rdat[1] !== 32'd200 || rcnt[1] !== 16'd4 || wcnt[1] !== 16'd4) begin
         bad++; $display("FAIL ret_rewind: got data=%0d rcnt=%0d wcnt=%0d want 200 4 4", rdat[1], rcnt[1], wcnt[1]);
      end
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 0, 1, i == 3, 0);
         total++;
         if (obs_rd !== 32'(200 + i)) begin
            bad++; $display("FAIL ret_reread: got %0d want %0d", obs_rd, 200 + i);
         end
      end
      total++;
      if (wcnt[1] !== 16'd0 || empt[1] !== 1'b1) begin
         bad++; $display("FAIL ret_commit: got wcnt=%0d empty=%b want 0 1", wcnt[1], empt[1]);
      end
   endtask
   task automatic test_full_rw();
      int nxt_w, nxt_r;
      sel = 0;
      do_reset();
      for (int i = 0; i < 8; i++) step(1, i, i == 7, 0, 0);
      step(1, 8, 1, 0, 1);
      total++;
      if (obs_wv !== 1'b0 || obs_rv !== 1'b1 || obs_rd !== 32'd0) begin
         bad++; $display("FAIL fullrw_edge: got wv=%b rv=%b data=%0d want 0 1 0", obs_wv, obs_rv, obs_rd);
      end
      step(1, 8, 1, 0, 1);
      total++;
      if (obs_wv !== 1'b1 || obs_rd !== 32'd1) begin
         bad++; $display("FAIL fullrw_next: got wv=%b data=%0d want 1 1", obs_wv, obs_rd);
      end
      nxt_w = 9; nxt_r = 2;
      for (int c = 0; c < 60 && nxt_r < 26; c++) begin
         step(1, nxt_w, 1, 0, 1);
         if (exp_wv) nxt_w++;
         if (obs_rv) begin
            total++;
            if (obs_rd !== 32'(nxt_r)) begin
               bad++; $display("FAIL wrap_order: got %0d want %0d", obs_rd, nxt_r);
            end
            nxt_r++;
         end
      end
      total++;
      if (nxt_r < 26) begin
         bad++; $display("FAIL wrap_timeout: got %0d reads want 26", nxt_r);
      end
   endtask
   task automatic test_dbg();
      sel = 0;
      do_reset();
      step(0, 0, 0, 0, 1);
      for (int i = 0; i < 12; i++) step(1, i, i == 7, 0, 0);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      total++;
      if ({wnm[0], wac[0], rnm[0], rac[0]} !== (DBG ? {16'd12, 16'd8, 16'd3, 16'd2} : 64'h0)) begin
         bad++; $display("FAIL dbg_counts: got %0d %0d %0d %0d want %0d %0d %0d %0d", wnm[0], wac[0], rnm[0], rac[0],
                         DBG ? 12 : 0, DBG ? 8 : 0, DBG ? 3 : 0, DBG ? 2 : 0);
      end
   endtask
   task automatic test_random();
      for (int k = 0; k < 2; k++) begin
         sel = k;
         do_reset();
         for (int c = 0; c < 400; c++) begin
            step($urandom_range(99) < 60, $urandom, $urandom_range(99) < 15, $urandom_range(99) < 5,
                 $urandom_range(99) < 50, $urandom_range(99) < 20, $urandom_range(99) < 5);
            total++;
            if (obs_wv !== exp_wv || obs_rv !== exp_rv || (exp_rv && obs_rd !== exp_rd)) begin
               bad++; $display("FAIL rnd_accept[%0d] c=%0d: got wv=%b rv=%b data=%h want %b %b %h",
                               k, c, obs_wv, obs_rv, obs_rd, exp_wv, exp_rv, exp_rd);
            end
            total++;
            if ({full[k], empt[k], pfull[k], topen[k], dlk[k]} !== {occ() == 8, cq.size() == 0, occ() >= 6, m_open, m_dl}) begin
               bad++; $display("FAIL rnd_flags[%0d] c=%0d: got %b want %b", k, c, {full[k], empt[k], pfull[k], topen[k], dlk[k]},
                               {occ() == 8, cq.size() == 0, occ() >= 6, m_open, m_dl});
            end
            total++;
            if ({wcnt[k], pcnt[k], rcnt[k]} !== {16'(occ()), 16'(pq.size()), 16'(cq.size())}) begin
               bad++; $display("FAIL rnd_counts[%0d] c=%0d: got %0d %0d %0d want %0d %0d %0d", k, c,
                               wcnt[k], pcnt[k], rcnt[k], occ(), pq.size(), cq.size());
            end
         end
      end
   endtask
   initial begin
      rst = 1; we = 0; wd = 0; ws = 0; wf = 0; re = 0; rs = 0; rf = 0;
      test_reset();
      test_commit();
      test_fail();
      test_deadlock();
      test_rd_return();
      test_full_rw();
      test_dbg();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
